// File: rtl/fpaddsub_align_pipe_pkg.sv
// Shared defaults and field-decode helpers for the FP add/sub alignment pipeline.
package fpaddsub_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int MAN_W_DEF  = 23;
  localparam int GRD_W_DEF  = 3;
  localparam int SIG_W_DEF  = MAN_W_DEF + 1;
  localparam int EXT_W_DEF  = SIG_W_DEF + GRD_W_DEF;
  localparam int SH_MAX_DEF = EXT_W_DEF;

  // Denormals and zero carry hidden bit 0 and behave as exponent 1.
  function automatic logic dec_hidden(input logic [31:0] exp_field);
    return (exp_field != 32'd0);
  endfunction

  function automatic logic [31:0] dec_eff_exp(input logic [31:0] exp_field);
    return (exp_field == 32'd0) ? 32'd1 : exp_field;
  endfunction

endpackage

// File: rtl/fpaddsub_align_pipe_if.sv
// Operand/result handshake bundle for the alignment pipeline.
interface fpaddsub_align_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRD_W = 3
);
  localparam int OP_W  = 1 + EXP_W + MAN_W;
  localparam int EXT_W = MAN_W + 1 + GRD_W;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_es;
  logic [EXT_W-1:0] out_mmax;
  logic [EXT_W-1:0] out_mmin;
  logic             out_smax;
  logic             out_eff_sub;
  logic             out_swap;
  logic             out_inf;
  logic             out_nan;

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_es, out_mmax, out_mmin,
           out_smax, out_eff_sub, out_swap, out_inf, out_nan
  );

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_es, out_mmax, out_mmin,
           out_smax, out_eff_sub, out_swap, out_inf, out_nan
  );
endinterface

// File: rtl/fpaddsub_align_pipe_sticky_shifter.sv
// Right shifter that folds every bit shifted out into the result LSB (sticky).
module fpaddsub_sticky_shifter #(
  parameter int EXT_W = 27,
  parameter int SH_W  = $clog2(EXT_W + 1)
) (
  input  logic [EXT_W-1:0] sig_i,
  input  logic [SH_W-1:0]  shamt_i,
  output logic [EXT_W-1:0] res_o
);
  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] lost_mask;
  logic             sticky;

  // A shift of EXT_W leaves shifted=0 and a full mask, so saturation needs no special case.
  assign shifted   = sig_i >> shamt_i;
  assign lost_mask = ~({EXT_W{1'b1}} << shamt_i);
  assign sticky    = |(sig_i & lost_mask);
  assign res_o     = {shifted[EXT_W-1:1], shifted[0] | sticky};
endmodule

// File: rtl/fpaddsub_align_pipe.sv
// Two-stage FP add/sub alignment: magnitude ordering, then sticky right-shift of the smaller significand.
module fpaddsub_align_pipe
  import fpaddsub_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int GRD_W = GRD_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  fpaddsub_align_pipe_if.slave bus
);
  localparam int SIG_W  = MAN_W + 1;
  localparam int EXT_W  = SIG_W + GRD_W;
  localparam int SH_MAX = EXT_W;
  localparam int SH_W   = $clog2(SH_MAX + 1);
  localparam int MAG_W  = EXP_W + MAN_W;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, eea, eeb;
  logic [MAN_W-1:0] fa, fb;
  logic             ha, hb;
  logic             inf_a, inf_b, nan_a, nan_b;
  logic             swap_d, eff_sub_d, smax_d, inf_d, nan_d;
  logic [EXP_W-1:0] emax_d, emin_d, diff_d;
  logic [SIG_W-1:0] mmax_d, mmin_d;

  assign {sa, ea, fa} = bus.in_a;
  assign {sb, eb, fb} = bus.in_b;

  assign ha  = dec_hidden(32'(ea));
  assign hb  = dec_hidden(32'(eb));
  assign eea = EXP_W'(dec_eff_exp(32'(ea)));
  assign eeb = EXP_W'(dec_eff_exp(32'(eb)));

  assign inf_a = (&ea) & ~(|fa);
  assign inf_b = (&eb) & ~(|fb);
  assign nan_a = (&ea) & (|fa);
  assign nan_b = (&eb) & (|fb);

  // Ties keep A as the larger operand.
  assign swap_d    = bus.in_b[MAG_W-1:0] > bus.in_a[MAG_W-1:0];
  assign eff_sub_d = sa ^ sb ^ bus.in_op;
  assign smax_d    = swap_d ? (sb ^ bus.in_op) : sa;
  assign inf_d     = inf_a | inf_b;
  assign nan_d     = nan_a | nan_b | (inf_a & inf_b & eff_sub_d);
  assign emax_d    = swap_d ? eeb : eea;
  assign emin_d    = swap_d ? eea : eeb;
  assign diff_d    = emax_d - emin_d;
  assign mmax_d    = swap_d ? {hb, fb} : {ha, fa};
  assign mmin_d    = swap_d ? {ha, fa} : {hb, fb};

  // Flow control: a stage advances when empty or when the stage after it drains.
  logic vld_p1_q, vld_p2_q, vld_p1_d, vld_p2_d;
  logic s1_load, s2_load;

  assign s2_load      = ~vld_p2_q | bus.out_ready;
  assign s1_load      = ~vld_p1_q | s2_load;
  assign bus.in_ready = s1_load;
  assign vld_p1_d     = s1_load ? bus.in_valid : vld_p1_q;
  assign vld_p2_d     = s2_load ? vld_p1_q : vld_p2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- stage 1: ordered operands ----
  logic             swap_p1_q, eff_sub_p1_q, smax_p1_q, inf_p1_q, nan_p1_q;
  logic [EXP_W-1:0] es_p1_q, diff_p1_q;
  logic [SIG_W-1:0] mmax_p1_q, mmin_p1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_p1_q    <= 1'b0;
      eff_sub_p1_q <= 1'b0;
      smax_p1_q    <= 1'b0;
      inf_p1_q     <= 1'b0;
      nan_p1_q     <= 1'b0;
      es_p1_q      <= '0;
      diff_p1_q    <= '0;
      mmax_p1_q    <= '0;
      mmin_p1_q    <= '0;
    end else if (s1_load && bus.in_valid) begin
      swap_p1_q    <= swap_d;
      eff_sub_p1_q <= eff_sub_d;
      smax_p1_q    <= smax_d;
      inf_p1_q     <= inf_d;
      nan_p1_q     <= nan_d;
      es_p1_q      <= emax_d;
      diff_p1_q    <= diff_d;
      mmax_p1_q    <= mmax_d;
      mmin_p1_q    <= mmin_d;
    end
  end

  logic [SH_W-1:0]  shamt_p1;
  logic [EXT_W-1:0] mmin_sh_p1;

  assign shamt_p1 = (32'(diff_p1_q) > 32'(SH_MAX)) ? SH_W'(SH_MAX) : SH_W'(diff_p1_q);

  fpaddsub_sticky_shifter #(
    .EXT_W (EXT_W),
    .SH_W  (SH_W)
  ) u_shift (
    .sig_i   ({mmin_p1_q, {GRD_W{1'b0}}}),
    .shamt_i (shamt_p1),
    .res_o   (mmin_sh_p1)
  );

  // ---- stage 2: aligned result ----
  logic             swap_p2_q, eff_sub_p2_q, smax_p2_q, inf_p2_q, nan_p2_q;
  logic [EXP_W-1:0] es_p2_q;
  logic [EXT_W-1:0] mmax_p2_q, mmin_p2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_p2_q    <= 1'b0;
      eff_sub_p2_q <= 1'b0;
      smax_p2_q    <= 1'b0;
      inf_p2_q     <= 1'b0;
      nan_p2_q     <= 1'b0;
      es_p2_q      <= '0;
      mmax_p2_q    <= '0;
      mmin_p2_q    <= '0;
    end else if (s2_load && vld_p1_q) begin
      swap_p2_q    <= swap_p1_q;
      eff_sub_p2_q <= eff_sub_p1_q;
      smax_p2_q    <= smax_p1_q;
      inf_p2_q     <= inf_p1_q;
      nan_p2_q     <= nan_p1_q;
      es_p2_q      <= es_p1_q;
      mmax_p2_q    <= {mmax_p1_q, {GRD_W{1'b0}}};
      mmin_p2_q    <= mmin_sh_p1;
    end
  end

  assign bus.out_valid   = vld_p2_q;
  assign bus.out_es      = es_p2_q;
  assign bus.out_mmax    = mmax_p2_q;
  assign bus.out_mmin    = mmin_p2_q;
  assign bus.out_smax    = smax_p2_q;
  assign bus.out_eff_sub = eff_sub_p2_q;
  assign bus.out_swap    = swap_p2_q;
  assign bus.out_inf     = inf_p2_q;
  assign bus.out_nan     = nan_p2_q;
endmodule

// File: tb/tb_fpaddsub_align_pipe.sv
// Bench for fpaddsub_align_pipe at single-precision defaults: vector table, random stream, stall and reset sequences.
module tb_fpaddsub_align_pipe;
  import fpaddsub_pkg::*;

  localparam int EXP_W = EXP_W_DEF;
  localparam int MAN_W = MAN_W_DEF;
  localparam int GRD_W = GRD_W_DEF;

  typedef struct packed {
    logic [7:0]  es;
    logic [26:0] mmax;
    logic [26:0] mmin;
    logic        smax;
    logic        eff_sub;
    logic        swap;
    logic        inf;
    logic        nan;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    res_t        r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpaddsub_align_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) bus ();

  fpaddsub_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic res_t cur_out();
    res_t r;
    r.es      = bus.out_es;
    r.mmax    = bus.out_mmax;
    r.mmin    = bus.out_mmin;
    r.smax    = bus.out_smax;
    r.eff_sub = bus.out_eff_sub;
    r.swap    = bus.out_swap;
    r.inf     = bus.out_inf;
    r.nan     = bus.out_nan;
    return r;
  endfunction

  task automatic cmp_res(input string tag, input res_t act, input res_t e);
    chk({tag, ".es"},      64'(act.es),      64'(e.es));
    chk({tag, ".mmax"},    64'(act.mmax),    64'(e.mmax));
    chk({tag, ".mmin"},    64'(act.mmin),    64'(e.mmin));
    chk({tag, ".smax"},    64'(act.smax),    64'(e.smax));
    chk({tag, ".eff_sub"}, 64'(act.eff_sub), 64'(e.eff_sub));
    chk({tag, ".swap"},    64'(act.swap),    64'(e.swap));
    chk({tag, ".inf"},     64'(act.inf),     64'(e.inf));
    chk({tag, ".nan"},     64'(act.nan),     64'(e.nan));
  endtask

  // Reference model, written bit-serially for the sticky accumulation.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    res_t        r;
    logic [7:0]  ea, eb;
    int          xa, xb, emax, emin, d;
    logic [23:0] siga, sigb, smin;
    logic [26:0] ext;
    logic        st, infa, infb;
    ea   = a[30:23];
    eb   = b[30:23];
    xa   = (ea == 8'd0) ? 1 : int'(ea);
    xb   = (eb == 8'd0) ? 1 : int'(eb);
    siga = {(ea != 8'd0), a[22:0]};
    sigb = {(eb != 8'd0), b[22:0]};
    r.swap    = (b[30:0] > a[30:0]);
    r.eff_sub = a[31] ^ b[31] ^ op;
    r.smax    = r.swap ? (b[31] ^ op) : a[31];
    emax   = r.swap ? xb : xa;
    emin   = r.swap ? xa : xb;
    r.es   = 8'(emax);
    r.mmax = {(r.swap ? sigb : siga), 3'b000};
    smin   = r.swap ? siga : sigb;
    ext    = {smin, 3'b000};
    d      = emax - emin;
    if (d >= 27) begin
      r.mmin = {26'd0, (ext != 27'd0)};
    end else begin
      st = 1'b0;
      for (int i = 0; i < d; i++) st = st | ext[i];
      r.mmin = (ext >> d) | {26'd0, st};
    end
    infa  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    infb  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    r.inf = infa || infb;
    r.nan = ((ea == 8'hFF) && (a[22:0] != 23'd0)) || ((eb == 8'hFF) && (b[22:0] != 23'd0)) ||
            (infa && infb && r.eff_sub);
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                              input logic [7:0] es, input logic [26:0] mmax, input logic [26:0] mmin,
                              input logic smax, input logic eff, input logic swp,
                              input logic inf, input logic nan);
    vec_t v;
    v.a = a; v.b = b; v.op = op;
    v.r = '{es, mmax, mmin, smax, eff, swp, inf, nan};
    return v;
  endfunction

  // Called right after a posedge; returns right after the posedge that accepted the item.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input res_t e);
    bit ok;
    ok = 1'b0;
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (ok) sb_q.push_back(e);
    else fail_now("in_ready_timeout");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb_q.size() != 0) fail_now("drain_timeout");
  endtask

  // Scoreboard: every output transfer must match the oldest outstanding expectation.
  res_t mon_exp;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) fail_now("unexpected_result");
      else begin
        mon_exp = sb_q.pop_front();
        cmp_res("result", cur_out(), mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rr;
    res_t        snap;

    tbl[0]  = mk(32'h3F800000, 32'h3F000000, 1'b0, 8'd127, 27'h4000000, 27'h2000000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h3F800001, 32'h4B800000, 1'b0, 8'd151, 27'h4000000, 27'h0000005, 0, 0, 1, 0, 0);
    tbl[2]  = mk(32'h3F800000, 32'h00000001, 1'b0, 8'd127, 27'h4000000, 27'h0000001, 0, 0, 0, 0, 0);
    tbl[3]  = mk(32'h00000000, 32'h00000000, 1'b0, 8'd1,   27'h0000000, 27'h0000000, 0, 0, 0, 0, 0);
    tbl[4]  = mk(32'h7F800000, 32'h7F800000, 1'b1, 8'd255, 27'h4000000, 27'h4000000, 0, 1, 0, 1, 1);
    tbl[5]  = mk(32'h7FC00000, 32'h3F800000, 1'b0, 8'd255, 27'h6000000, 27'h0000001, 0, 0, 0, 0, 1);
    tbl[6]  = mk(32'h3F800000, 32'h40000000, 1'b1, 8'd128, 27'h4000000, 27'h2000000, 1, 1, 1, 0, 0);
    tbl[7]  = mk(32'hC0400000, 32'h3F800000, 1'b0, 8'd128, 27'h6000000, 27'h2000000, 1, 1, 0, 0, 0);
    tbl[8]  = mk(32'h00000003, 32'h00000002, 1'b0, 8'd1,   27'h0000018, 27'h0000010, 0, 0, 0, 0, 0);
    tbl[9]  = mk(32'h4C000000, 32'h3F800001, 1'b0, 8'd152, 27'h4000000, 27'h0000003, 0, 0, 0, 0, 0);
    tbl[10] = mk(32'h4D000000, 32'h3F800000, 1'b0, 8'd154, 27'h4000000, 27'h0000001, 0, 0, 0, 0, 0);
    tbl[11] = mk(32'h3F800000, 32'hFF800000, 1'b0, 8'd255, 27'h4000000, 27'h0000001, 1, 1, 1, 1, 0);

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
    cmp_res("reset.data", cur_out(), '0);
    @(posedge clk); #1;
    chk("reset.in_ready", 64'(bus.in_ready), 64'd1);

    // First vector alone to pin the latency, then the rest back-to-back.
    send(tbl[0].a, tbl[0].b, tbl[0].op, tbl[0].r);
    chk("latency.early", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("latency.valid", 64'(bus.out_valid), 64'd1);
    for (int i = 1; i < 12; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r);
    drain();

    for (int i = 0; i < 24; i++) begin
      ra = $urandom();
      rr = $urandom();
      rb = (i % 2 == 0) ? $urandom() : {rr[31], ra[30:23] - 8'(rr % 30), rr[22:0]};
      send(ra, rb, rr[7], model(ra, rb, rr[7]));
    end
    drain();

    // Backpressure: four back-to-back items, sink stalls 3 cycles from the first result.
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          ra = 32'h3F800000 + (i << 20);
          rb = 32'h3E000000 + (i << 3);
          send(ra, rb, i[0], model(ra, rb, i[0]));
        end
      end
      begin
        for (int n = 0; n < 50; n++) begin
          @(posedge clk); #1;
          if (bus.out_valid) break;
        end
        chk("bp.first_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        snap = cur_out();
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp.in_ready_low", 64'(bus.in_ready), 64'd0);
          chk("bp.valid_held", 64'(bus.out_valid), 64'd1);
          cmp_res("bp.stable", cur_out(), snap);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two items in flight: both must vanish.
    bus.out_ready = 1'b0;
    send(32'h40400000, 32'h3F800000, 1'b0, model(32'h40400000, 32'h3F800000, 1'b0));
    send(32'h41000000, 32'h40000000, 1'b1, model(32'h41000000, 32'h40000000, 1'b1));
    rst = 1'b1;
    #1;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst.no_stale", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(tbl[1].a, tbl[1].b, tbl[1].op, tbl[1].r);
    chk("rst.fresh_early", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("rst.fresh_valid", 64'(bus.out_valid), 64'd1);
    drain();

    repeat (3) @(posedge clk);
    chk("final.queue_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpaddsub_align_pipe.md
Name: fpaddsub_align_pipe

Overview:
- Parametrised, pipelined successor to the combinational FP add/sub alignment stage.
- Accepts two IEEE754-style operands plus an add/sub opcode and orders them by magnitude.
- Right-shifts the smaller significand into a guard-extended field with a sticky bit, and flags inf/NaN operands.
- Sits between operand capture and the significand adder. Two-stage pipeline with valid/ready flow control.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; significand is MAN_W+1 bits with the hidden bit
- GRD_W, 3, guard/round/sticky bits appended below the significand (minimum 2); LSB carries sticky

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- in_a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
- in_b  in  1+EXP_W+MAN_W  operand B
- in_op  in  1  0 = add, 1 = subtract (A-B)
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- out_es  out  EXP_W  common (larger effective) exponent
- out_mmax  out  MAN_W+1+GRD_W  larger significand, GRD_W zeros appended
- out_mmin  out  MAN_W+1+GRD_W  shifted smaller significand, LSB = sticky OR
- out_smax  out  1  sign of larger-magnitude operand, after the op is applied
- out_eff_sub  out  1  effective subtraction = sa ^ sb ^ op
- out_swap  out  1  1 = B was larger in magnitude
- out_inf  out  1  either operand is infinity (exp all ones, frac 0)
- out_nan  out  1  either operand is NaN, or inf-inf under effective subtraction

Behaviour:
- Reset: all valid flags cleared. All output data registers cleared to 0. out_valid=0; in_ready=1 the cycle after reset releases.
- Reset mid-operation discards both in-flight stages. No result is emitted for them.
- Field decode: exp==0 → hidden bit 0 and effective exponent 1 (denormal/zero). Otherwise hidden bit 1 and effective exponent = exp.
- Stage 1, registered at the S1 load:
  - swap = (B[EXP_W+MAN_W-1:0] > A[EXP_W+MAN_W-1:0]). Equal magnitudes → swap=0, A is max.
  - Emax and Emin are taken from the effective exponents.
  - diff = Emax-Emin, unsigned EXP_W bits. It is never negative.
  - Significands are selected by swap.
  - Sign of max: A.sign if swap=0; B.sign^op if swap=1.
  - Compute eff_sub, inf and nan.
- Stage 2, registered at the S2 load:
  - shamt = min(diff, MAN_W+1+GRD_W).
  - mmin_ext = {Mmin, GRD_W zeros} >> shamt.
  - sticky = OR of all bits shifted out; out_mmin = mmin_ext | sticky in the LSB.
  - shamt at saturation: out_mmin = {0…0, sticky}, where sticky = (Mmin≠0).
- Latency: 2 cycles from an in_valid&in_ready edge to out_valid, with no stalls. Throughput is 1 per cycle.
- Flow control:
  - s2_load = ~v2 | out_ready.
  - s1_load = ~v1 | s2_load.
  - in_ready = s1_load, combinational from out_ready; no combinational path from in_valid.
  - On s1_load, v1 <= in_valid. On s2_load, v2 <= v1.
  - Data registers load only when the corresponding stage is loaded with a valid item.
- Stall: with out_valid=1 and out_ready=0, all out_* stay bit-stable and in_ready=0 if v1=1. Nothing is dropped or duplicated.
- Simultaneous accept and emit in the same cycle is allowed; both stages advance.
- NaN/inf inputs still flow through alignment. Flags are advisory; downstream selects the special result.

Decomposition:
- Package fpaddsub_pkg holds:
  - EXP_W/MAN_W/GRD_W defaults
  - derived SIG_W = MAN_W+1
  - EXT_W = SIG_W+GRD_W
  - SH_MAX = EXT_W
  - the decode function for the effective exponent and hidden bit
- One sub-module, fpaddsub_sticky_shifter: combinational, parameter EXT_W. Inputs are a significand and shamt; output is the shifted value with sticky in the LSB. Instantiated in stage 2.

Test Plan (defaults, single precision, EXT_W=27):
- A=0x3F800000, B=0x3F000000, op=0 → after 2 cycles: es=127, mmax=0x4000000, mmin=0x2000000, swap=0, eff_sub=0, smax=0.
- A=0x3F800001, B=0x4B800000 (diff 24) → swap=1, es=151, mmax=0x4000000, mmin=0x0000005 (sticky set).
- A=0x3F800000, B=0x00000001 (denormal, diff 126, saturates) → mmin=0x0000001; A=B=0 → es=1, mmax=0, mmin=0, swap=0.
- A=0x7F800000, B=0x7F800000, op=1 → inf=1, nan=1; A=0x7FC00000 → nan=1.
- Backpressure: stream 4 operands back-to-back, hold out_ready=0 for 3 cycles after the first out_valid → outputs stable, in_ready=0 while both stages are full, all 4 results emitted in order, none lost.
- Assert rst while 2 items are in flight → out_valid=0 immediately; after release, no stale result appears; a fresh operand produces a correct result 2 cycles later.
